// File: rtl/rlbp_rx_pkg.sv
// Shared types and defaults for the RLBP serial readout receiver.
// Optional parity support is enabled with RLBP_READOUT_RX_PARITY_EN.
package rlbp_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    WAIT_DONE
  } state_e;

  localparam int CODE_W_DEF  = 8;
  localparam int WPF_DEF     = 9;
  localparam int SYNC_STAGES = 2;
  localparam int FRM_CNT_W   = 16;

  function automatic logic odd_ones(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rlbp_rx_fifo.sv
// Synchronous word FIFO; head is presented from registered storage.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module rlbp_rx_fifo
  import rlbp_rx_pkg::*;
#(
  parameter int W     = CODE_W_DEF + 1,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [LW-1:0] r_cnt;

  logic w_pop;
  logic w_wr;

  assign o_full  = (r_cnt == LW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_level = r_cnt;
  assign w_pop   = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_pop);
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + LW'(w_wr) - LW'(w_pop);
    end
  end

endmodule

// File: rtl/rlbp_readout_rx.sv
// Oversampling receiver for the pixel-macro serial readout link.
// Define RLBP_READOUT_RX_PARITY_EN for a per-word even-parity bit.
module rlbp_readout_rx
  import rlbp_rx_pkg::*;
#(
  parameter int CODE_W          = CODE_W_DEF,
  parameter int WORDS_PER_FRAME = WPF_DEF,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            rx_en_i,
  input  logic                            ser_clk_i,
  input  logic                            ser_data_i,
  input  logic                            ser_start_i,
  input  logic                            ser_done_i,
  output logic                            rd_valid_o,
  input  logic                            rd_ready_i,
  output logic [CODE_W-1:0]               rd_data_o,
  output logic                            rd_last_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
  output logic [FRM_CNT_W-1:0]            frame_cnt_o,
  output logic                            ovf_err_o,
  output logic                            frm_err_o,
`ifdef RLBP_READOUT_RX_PARITY_EN
  output logic                            par_err_o,
`endif
  input  logic                            err_clr_i,
  output logic                            irq_o
);

  localparam int BW = $clog2(CODE_W);
  localparam int WW = $clog2(WORDS_PER_FRAME + 1);
  localparam int SS = SYNC_STAGES;

  logic [SS-1:0] r_clk_sy;
  logic [SS-1:0] r_dat_sy;
  logic [SS-1:0] r_sta_sy;
  logic [SS-1:0] r_don_sy;
  logic          r_clk_d;
  logic          r_sta_d;
  logic          r_don_d;

  state_e              r_state;
  logic [BW-1:0]       r_bit_cnt;
  logic [WW-1:0]       r_word_cnt;
  logic [CODE_W-1:0]   r_sh;
  logic [FRM_CNT_W-1:0] r_frm_cnt;
  logic                r_irq;
  logic                r_ovf;
  logic                r_frm;

  logic              w_clk_rise;
  logic              w_sta_rise;
  logic              w_don_rise;
  logic              w_bit;
  logic              w_last;
  state_e            w_st;
  logic [BW-1:0]     w_bit_n;
  logic [WW-1:0]     w_word_n;
  logic [CODE_W-1:0] w_sh_n;
  logic              w_push;
  logic              w_frm_set;
  logic              w_good;
  logic              w_par_set;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_set;
  logic [CODE_W:0]   w_rdata;

  // Data rides the same synchroniser depth as the bit clock
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_clk_sy <= '0;
      r_dat_sy <= '0;
      r_sta_sy <= '0;
      r_don_sy <= '0;
      r_clk_d  <= 1'b0;
      r_sta_d  <= 1'b0;
      r_don_d  <= 1'b0;
    end else begin
      r_clk_sy <= {r_clk_sy[SS-2:0], ser_clk_i};
      r_dat_sy <= {r_dat_sy[SS-2:0], ser_data_i};
      r_sta_sy <= {r_sta_sy[SS-2:0], ser_start_i};
      r_don_sy <= {r_don_sy[SS-2:0], ser_done_i};
      r_clk_d  <= r_clk_sy[SS-1];
      r_sta_d  <= r_sta_sy[SS-1];
      r_don_d  <= r_don_sy[SS-1];
    end
  end

  assign w_clk_rise = r_clk_sy[SS-1] & ~r_clk_d;
  assign w_sta_rise = r_sta_sy[SS-1] & ~r_sta_d;
  assign w_don_rise = r_don_sy[SS-1] & ~r_don_d;
  assign w_bit      = r_dat_sy[SS-1];
  assign w_last     = (r_word_cnt == WW'(WORDS_PER_FRAME - 1));

  always_comb begin
    w_st      = r_state;
    w_bit_n   = r_bit_cnt;
    w_word_n  = r_word_cnt;
    w_sh_n    = r_sh;
    w_push    = 1'b0;
    w_frm_set = 1'b0;
    w_good    = 1'b0;
    w_par_set = 1'b0;
    // Bit clock is handled first so a final bit plus done completes a frame
    unique case (r_state)
      IDLE: ;
      SHIFT: begin
        if (w_clk_rise) begin
          w_sh_n = {r_sh[CODE_W-2:0], w_bit};
          if (r_bit_cnt == BW'(CODE_W - 1)) begin
            w_bit_n = '0;
`ifdef RLBP_READOUT_RX_PARITY_EN
            w_st = PARITY;
`else
            w_push = 1'b1;
            if (w_last) w_st = WAIT_DONE;
            else w_word_n = r_word_cnt + 1'b1;
`endif
          end else begin
            w_bit_n = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef RLBP_READOUT_RX_PARITY_EN
      PARITY: begin
        if (w_clk_rise) begin
          w_push    = 1'b1;
          w_par_set = odd_ones(32'({r_sh, w_bit}));
          if (w_last) begin
            w_st = WAIT_DONE;
          end else begin
            w_st     = SHIFT;
            w_word_n = r_word_cnt + 1'b1;
          end
        end
      end
`endif
      WAIT_DONE: begin
        if (w_clk_rise) w_frm_set = 1'b1;
      end
      default: w_st = IDLE;
    endcase

    if (r_state == IDLE) begin
      if (w_sta_rise) begin
        w_st     = SHIFT;
        w_bit_n  = '0;
        w_word_n = '0;
      end
    end else if (w_sta_rise) begin
      w_frm_set = 1'b1;
      w_st      = SHIFT;
      w_bit_n   = '0;
      w_word_n  = '0;
    end else if (w_don_rise) begin
      if (w_st == WAIT_DONE) w_good = 1'b1;
      else w_frm_set = 1'b1;
      w_st = IDLE;
    end

    if (!rx_en_i) begin
      w_st      = IDLE;
      w_bit_n   = '0;
      w_word_n  = '0;
      w_push    = 1'b0;
      w_frm_set = 1'b0;
      w_good    = 1'b0;
      w_par_set = 1'b0;
    end
  end

  assign w_ovf_set = w_push & w_full & ~(rd_ready_i & ~w_empty);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_sh       <= '0;
      r_frm_cnt  <= '0;
      r_irq      <= 1'b0;
      r_ovf      <= 1'b0;
      r_frm      <= 1'b0;
    end else begin
      r_state    <= w_st;
      r_bit_cnt  <= w_bit_n;
      r_word_cnt <= w_word_n;
      r_sh       <= w_sh_n;
      r_irq      <= w_good;
      if (w_good) r_frm_cnt <= r_frm_cnt + 1'b1;
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (err_clr_i) r_ovf <= 1'b0;
      if (w_frm_set) r_frm <= 1'b1;
      else if (err_clr_i) r_frm <= 1'b0;
    end
  end

`ifdef RLBP_READOUT_RX_PARITY_EN
  logic r_par;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_par <= 1'b0;
    else if (w_par_set) r_par <= 1'b1;
    else if (err_clr_i) r_par <= 1'b0;
  end

  assign par_err_o = r_par;
`endif

  rlbp_rx_fifo #(
    .W     (CODE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (w_push),
    .i_wdata ({w_last, w_sh_n}),
    .i_pop   (rd_ready_i),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

  assign rd_valid_o  = ~w_empty;
  assign rd_data_o   = w_rdata[CODE_W-1:0];
  assign rd_last_o   = w_rdata[CODE_W];
  assign frame_cnt_o = r_frm_cnt;
  assign ovf_err_o   = r_ovf;
  assign frm_err_o   = r_frm;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_rlbp_readout_rx.sv
// Scoreboard bench for rlbp_readout_rx: frame-level model feeds an expected-word queue.
// Parity scenario runs when RLBP_READOUT_RX_PARITY_EN is defined.
module tb_rlbp_readout_rx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b0;
  logic        sclk = 1'b0;
  logic        sdat = 1'b0;
  logic        ssta = 1'b0;
  logic        sdon = 1'b0;
  logic        rdy = 1'b0;
  logic        clr = 1'b0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic [4:0]  level;
  logic [15:0] frame_cnt;
  logic        ovf;
  logic        frm;
  logic        irq;
`ifdef RLBP_READOUT_RX_PARITY_EN
  logic        par;
`endif

  rlbp_readout_rx #(
    .CODE_W          (8),
    .WORDS_PER_FRAME (9),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx_en_i     (rx_en),
    .ser_clk_i   (sclk),
    .ser_data_i  (sdat),
    .ser_start_i (ssta),
    .ser_done_i  (sdon),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rdy),
    .rd_data_o   (rd_data),
    .rd_last_o   (rd_last),
    .level_o     (level),
    .frame_cnt_o (frame_cnt),
    .ovf_err_o   (ovf),
    .frm_err_o   (frm),
`ifdef RLBP_READOUT_RX_PARITY_EN
    .par_err_o   (par),
`endif
    .err_clr_i   (clr),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         irq_seen = 0;
  int         exp_frames = 0;
  bit         rand_rdy = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] fr [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word must match the model queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (irq) irq_seen++;
      if (rd_valid && rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none",
                   {rd_last, rd_data});
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_word", {23'd0, rd_last, rd_data}, {23'd0, mon_e});
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit popwin);
    sclk = 1'b0;
    sdat = b;
    tick(4);
    sclk = 1'b1;
    if (popwin) begin
      tick(2);
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
      tick(1);
    end else begin
      tick(4);
    end
  endtask

  task automatic strobe_start();
    ssta = 1'b1;
    tick(4);
    ssta = 1'b0;
    tick(4);
  endtask

  task automatic strobe_done();
    sdon = 1'b1;
    tick(4);
    sdon = 1'b0;
    tick(4);
  endtask

  // Model: word lands in FIFO unless FIFO is full with no pop that cycle
  task automatic send_word(input logic [7:0] w, input bit last,
                           input bit popwin, input bit pflip);
    logic [7:0] v;
    v = w;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
    if (!(exp_q.size() >= DEPTH && !popwin)) exp_q.push_back({last, w});
`ifdef RLBP_READOUT_RX_PARITY_EN
    send_bit(v[0], 1'b0);
    send_bit((^v) ^ pflip, popwin);
`else
    if (pflip) $display("note: parity flip ignored in this build");
    send_bit(v[0], popwin);
`endif
  endtask

  task automatic send_frame();
    strobe_start();
    for (int i = 0; i < 9; i++) send_word(fr[i], i == 8, 1'b0, 1'b0);
    strobe_done();
    exp_frames++;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    rdy = 1'b1;
    while (exp_q.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    tick(2);
    chk(name, exp_q.size(), 0);
    chk({name, "_level"}, {27'd0, level}, 0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_valid", {31'd0, rd_valid}, 0);
    chk("rst_data", {24'd0, rd_data}, 0);
    chk("rst_level", {27'd0, level}, 0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
    chk("rst_errs", {29'd0, ovf, frm, irq}, 0);
    rst = 1'b0;
    rx_en = 1'b1;
    tick(2);

    // Basic frame 0x01..0x09, consumer always ready
    rdy = 1'b1;
    for (int i = 0; i < 9; i++) fr[i] = 8'(i + 1);
    send_frame();
    tick(10);
    chk("t1_frame_cnt", {16'd0, frame_cnt}, 1);
    chk("t1_irq", irq_seen, 1);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_errs", {30'd0, ovf, frm}, 0);

    // Stalled consumer: two frames overflow the FIFO
    rdy = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 9; i++) fr[i] = 8'($urandom);
      send_frame();
    end
    tick(4);
    chk("t2_level", {27'd0, level}, exp_q.size());
    chk("t2_full", {27'd0, level}, DEPTH);
    chk("t2_ovf", {31'd0, ovf}, 1);
    chk("t2_frame_cnt", {16'd0, frame_cnt}, exp_frames);

    // Full FIFO, pop on the exact push cycle: no overflow
    pulse_clr();
    chk("t5_ovf_clr", {31'd0, ovf}, 0);
    strobe_start();
    send_word(8'h5A, 1'b0, 1'b1, 1'b0);
    tick(4);
    chk("t5_ovf", {31'd0, ovf}, 0);
    chk("t5_level", {27'd0, level}, DEPTH);
    rx_en = 1'b0;
    tick(2);
    rx_en = 1'b1;
    chk("t5_no_frm", {31'd0, frm}, 0);
    drain("t5_drain");

    // Done after 3 words + 5 bits
    strobe_start();
    for (int i = 0; i < 3; i++) send_word(8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    strobe_done();
    tick(10);
    chk("t3_frm", {31'd0, frm}, 1);
    chk("t3_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    chk("t3_irq", irq_seen, exp_frames);
    drain("t3_drain");
    pulse_clr();
    chk("clr_errs", {30'd0, ovf, frm}, 0);

    // Restart mid word 2, then a full frame 0xA0..0xA8
    strobe_start();
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    for (int i = 0; i < 9; i++) fr[i] = 8'hA0 + 8'(i);
    send_frame();
    tick(10);
    chk("t4_frm", {31'd0, frm}, 1);
    chk("t4_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    drain("t4_drain");
    pulse_clr();

    // Randomized frames with a random-ready consumer
    rand_rdy = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 9; i++) fr[i] = 8'($urandom);
      send_frame();
      tick($urandom_range(0, 20));
    end
    rand_rdy = 1'b0;
    tick(2);
    drain("rnd_drain");
    chk("rnd_frame_cnt", {16'd0, frame_cnt}, exp_frames);
    chk("rnd_irq", irq_seen, exp_frames);
    chk("rnd_errs", {30'd0, ovf, frm}, 0);

`ifdef RLBP_READOUT_RX_PARITY_EN
    // Word 0x55 with parity bit 1 (even parity says 0)
    strobe_start();
    send_word(8'h55, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 9; i++) send_word(8'(i), i == 8, 1'b0, 1'b0);
    strobe_done();
    exp_frames++;
    tick(10);
    chk("t6_par", {31'd0, par}, 1);
    drain("t6_drain");
    pulse_clr();
    chk("t6_par_clr", {31'd0, par}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
